// File: rtl/liic_dn_link_bridge_if.sv
// Link-layer packet channel (data, start/end of packet, valid/ready) used for the
// high- and low-priority LIIC channels in both directions.
interface liic_dn_link_bridge_if #(
  parameter int W = 8
);
  logic [W-1:0] dat;
  logic         val;
  logic         sop;
  logic         eop;
  logic         rdy;

  modport master (output dat, val, sop, eop, input rdy);
  modport slave  (input dat, val, sop, eop, output rdy);
endinterface

// File: rtl/liic_dn_link_bridge.sv
// Downstream LIIC bridge: MM slave tunnelled over the high-priority channel, stream over
// the low-priority channel, link reset supervision and CSRs. Define LIIC_DN_LINK_UPTIME_EN for UPTIME.
module liic_dn_link_bridge #(
  parameter int ST_WIDTH       = 8,
  parameter int CS_WIDTH       = 8,
  parameter int MM_MAXPENDRD   = 8,
  parameter int MM_BUSYTIMEOUT = 128,
  parameter int MM_RVALTIMEOUT = 128,
  parameter int LL_RSTLENGTH   = 5,
  parameter int LL_RSTPERIOD   = 25,
  parameter int CLK_FREQUENCY  = 2000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          cs_addr,
  input  logic                cs_wreq,
  input  logic [CS_WIDTH-1:0] cs_wdat,
  input  logic                cs_rreq,
  output logic [CS_WIDTH-1:0] cs_rdat,
  output logic                cs_rval,
  output logic                cs_busy,
  input  logic [ST_WIDTH-1:0] mm_addr,
  input  logic                mm_wreq,
  input  logic [ST_WIDTH-1:0] mm_wdat,
  input  logic                mm_rreq,
  output logic [ST_WIDTH-1:0] mm_rdat,
  output logic                mm_rval,
  output logic                mm_busy,
  input  logic [ST_WIDTH-1:0] st_i_dat,
  input  logic                st_i_val,
  input  logic                st_i_eop,
  output logic                st_i_rdy,
  output logic [ST_WIDTH-1:0] st_o_dat,
  output logic                st_o_val,
  output logic                st_o_eop,
  input  logic                st_o_rdy,
  input  logic                ll_linkup,
  output logic                ll_reset,
  liic_dn_link_bridge_if.slave  llhp_i,
  liic_dn_link_bridge_if.master llhp_o,
  liic_dn_link_bridge_if.slave  lllp_i,
  liic_dn_link_bridge_if.master lllp_o
);
  localparam int PW = $clog2(MM_MAXPENDRD + 1);
  localparam int BW = $clog2(MM_BUSYTIMEOUT + 1);
  localparam int RW = $clog2(MM_RVALTIMEOUT + 1);
  localparam int LW = $clog2(LL_RSTPERIOD);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_ADDR, S_DATA} ser_state_t;

  ser_state_t          state, state_nxt;
  logic [ST_WIDTH-1:0] req_addr, req_wdat;
  logic                req_write, lp_first;
  logic [PW-1:0]       pending;
  logic [BW-1:0]       bto_cnt;
  logic [RW-1:0]       rto_cnt;
  logic [LW-1:0]       rst_cnt;
  logic [1:0]          ctrl;
  logic [CS_WIDTH-1:0] errcnt, uptime_sec, cs_rd_mux;
  logic [CS_WIDTH:0]   err_sum;
  logic req_any, busy_raw, accept, drop, rd_accept, rd_drop, resp, rto_hit, auto_run;
  logic unused_freq, unused_ok;

  // Low-priority channel is a straight pass-through; only sop needs state.
  assign lllp_o.dat = st_i_dat;
  assign lllp_o.val = st_i_val;
  assign lllp_o.eop = st_i_eop;
  assign lllp_o.sop = lp_first;
  assign st_i_rdy   = lllp_o.rdy;
  assign st_o_dat   = lllp_i.dat;
  assign st_o_val   = lllp_i.val;
  assign st_o_eop   = lllp_i.eop;
  assign lllp_i.rdy = st_o_rdy;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                          lp_first <= 1'b1;
    else if (st_i_val && lllp_o.rdy)  lp_first <= st_i_eop;
  end

  assign req_any   = mm_wreq | mm_rreq;
  assign busy_raw  = (state != S_IDLE) | (mm_rreq & (pending == PW'(MM_MAXPENDRD))) | ~ll_linkup;
  assign drop      = req_any & busy_raw & (bto_cnt == BW'(MM_BUSYTIMEOUT));
  assign mm_busy   = busy_raw & ~drop;
  assign accept    = req_any & ~busy_raw;
  assign rd_accept = accept & ~mm_wreq;
  assign rd_drop   = drop & ~mm_wreq;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    llhp_o.val = 1'b0;
    llhp_o.sop = 1'b0;
    llhp_o.eop = 1'b0;
    llhp_o.dat = '0;
    case (state)
      S_IDLE: if (accept) state_nxt = S_HDR;
      S_HDR: begin
        llhp_o.val = 1'b1;
        llhp_o.sop = 1'b1;
        llhp_o.dat = ST_WIDTH'(req_write);
        if (llhp_o.rdy) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        llhp_o.val = 1'b1;
        llhp_o.eop = ~req_write;
        llhp_o.dat = req_addr;
        if (llhp_o.rdy) state_nxt = req_write ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        llhp_o.val = 1'b1;
        llhp_o.eop = 1'b1;
        llhp_o.dat = req_wdat;
        if (llhp_o.rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Losing the link aborts the packet; a read in flight stays counted as pending.
    if (!ll_linkup) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdat  <= '0;
    end else if (accept) begin
      req_write <= mm_wreq;
      req_addr  <= mm_addr;
      req_wdat  <= mm_wdat;
    end
  end

  // Busy timeout; a read waiting behind outstanding reads is not timed out.
  always_ff @(posedge clk) begin
    if (rst || !req_any || accept || drop)                          bto_cnt <= '0;
    else if (busy_raw && !(mm_rreq && !mm_wreq && pending != '0))   bto_cnt <= bto_cnt + 1'b1;
  end

  assign llhp_i.rdy = 1'b1;
  assign resp       = llhp_i.val & llhp_i.eop & (pending != '0);
  assign rto_hit    = (pending != '0) & (rto_cnt == RW'(MM_RVALTIMEOUT)) & ~resp;

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending + PW'(rd_accept) - PW'(resp | rto_hit);
  end

  always_ff @(posedge clk) begin
    if (rst || resp || rto_hit || (rd_accept && pending == '0)) rto_cnt <= '0;
    else if (pending != '0)                                     rto_cnt <= rto_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mm_rval <= 1'b0;
      mm_rdat <= '0;
    end else begin
      mm_rval <= resp | rto_hit | rd_drop;
      if (resp)                  mm_rdat <= llhp_i.dat;
      else if (rto_hit || rd_drop) mm_rdat <= '0;
    end
  end

  // Control/status registers.
  assign err_sum = {1'b0, errcnt} + (CS_WIDTH+1)'(drop) + (CS_WIDTH+1)'(rto_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= 2'b10;
      errcnt <= '0;
    end else begin
      if (cs_wreq && cs_addr == 4'd0) ctrl <= cs_wdat[1:0];
      if (cs_wreq && cs_addr == 4'd3) errcnt <= '0;
      else                            errcnt <= err_sum[CS_WIDTH] ? '1 : err_sum[CS_WIDTH-1:0];
    end
  end

`ifdef LIIC_DN_LINK_UPTIME_EN
  localparam int TW = $clog2(CLK_FREQUENCY);
  logic [TW-1:0] tick_cnt;

  always_ff @(posedge clk) begin
    if (rst || !ll_linkup) begin
      tick_cnt   <= '0;
      uptime_sec <= '0;
    end else if (tick_cnt == TW'(CLK_FREQUENCY - 1)) begin
      tick_cnt <= '0;
      if (uptime_sec != '1) uptime_sec <= uptime_sec + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end
  assign unused_freq = 1'b0;
`else
  assign uptime_sec  = '0;
  assign unused_freq = (CLK_FREQUENCY != 0);
`endif

  always_comb begin
    cs_rd_mux = '0;
    case (cs_addr)
      4'd0:    cs_rd_mux = CS_WIDTH'(ctrl);
      4'd1:    cs_rd_mux = CS_WIDTH'({pending != '0, ll_reset, ll_linkup});
      4'd2:    cs_rd_mux = uptime_sec;
      4'd3:    cs_rd_mux = errcnt;
      default: cs_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_rval <= 1'b0;
      cs_rdat <= '0;
    end else begin
      cs_rval <= cs_rreq;
      if (cs_rreq) cs_rdat <= cs_rd_mux;
    end
  end
  assign cs_busy = 1'b0;

  // Link reset: forced, or periodic pulses while the link is down and auto-reset is on.
  assign auto_run = ctrl[1] & ~ctrl[0] & ~ll_linkup;

  always_ff @(posedge clk) begin
    if (rst || !auto_run) rst_cnt <= '0;
    else                  rst_cnt <= (rst_cnt == LW'(LL_RSTPERIOD - 1)) ? '0 : rst_cnt + 1'b1;
  end
  assign ll_reset = rst | ctrl[0] | (auto_run & (rst_cnt < LW'(LL_RSTLENGTH)));

  assign unused_ok = ^{lllp_i.sop, llhp_i.sop, cs_wdat[CS_WIDTH-1:2], unused_freq};
endmodule

// File: tb/tb_liic_dn_link_bridge.sv
// Scoreboard bench for liic_dn_link_bridge: stimulus pushes expected words/responses into
// queues, independent negedge monitors pop and compare whenever the DUT presents output.
module tb_liic_dn_link_bridge;
  localparam int W  = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]    cs_addr;
  logic          cs_wreq, cs_rreq, cs_rval, cs_busy;
  logic [CW-1:0] cs_wdat, cs_rdat;
  logic [W-1:0]  mm_addr, mm_wdat, mm_rdat;
  logic          mm_wreq, mm_rreq, mm_rval, mm_busy;
  logic [W-1:0]  st_i_dat, st_o_dat;
  logic          st_i_val, st_i_eop, st_i_rdy, st_o_val, st_o_eop, st_o_rdy;
  logic          ll_linkup, ll_reset;

  liic_dn_link_bridge_if #(.W(W)) llhp_i ();
  liic_dn_link_bridge_if #(.W(W)) llhp_o ();
  liic_dn_link_bridge_if #(.W(W)) lllp_i ();
  liic_dn_link_bridge_if #(.W(W)) lllp_o ();

  liic_dn_link_bridge dut (
    .clk(clk), .rst(rst),
    .cs_addr(cs_addr), .cs_wreq(cs_wreq), .cs_wdat(cs_wdat), .cs_rreq(cs_rreq),
    .cs_rdat(cs_rdat), .cs_rval(cs_rval), .cs_busy(cs_busy),
    .mm_addr(mm_addr), .mm_wreq(mm_wreq), .mm_wdat(mm_wdat), .mm_rreq(mm_rreq),
    .mm_rdat(mm_rdat), .mm_rval(mm_rval), .mm_busy(mm_busy),
    .st_i_dat(st_i_dat), .st_i_val(st_i_val), .st_i_eop(st_i_eop), .st_i_rdy(st_i_rdy),
    .st_o_dat(st_o_dat), .st_o_val(st_o_val), .st_o_eop(st_o_eop), .st_o_rdy(st_o_rdy),
    .ll_linkup(ll_linkup), .ll_reset(ll_reset),
    .llhp_i(llhp_i), .llhp_o(llhp_o), .lllp_i(lllp_i), .lllp_o(lllp_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W+1:0]  exp_hp[$];  // {sop, eop, dat}
  logic [W+1:0]  exp_lp[$];  // {sop, eop, dat}
  logic [W:0]    exp_st[$];  // {eop, dat}
  logic [W-1:0]  exp_rd[$];
  logic [CW-1:0] exp_cs[$];
  bit hp_bp = 1'b0, lp_bp = 1'b0, st_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input string msg);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: %s", name, msg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors
  always @(negedge clk) begin
    if (!rst) begin
      if (llhp_o.val && llhp_o.rdy) begin
        if (exp_hp.size() == 0) report_fail("hp_word", "unexpected high-priority word");
        else check("hp_word", {llhp_o.sop, llhp_o.eop, llhp_o.dat}, exp_hp.pop_front());
      end
      if (lllp_o.val && lllp_o.rdy) begin
        if (exp_lp.size() == 0) report_fail("lp_word", "unexpected low-priority word");
        else check("lp_word", {lllp_o.sop, lllp_o.eop, lllp_o.dat}, exp_lp.pop_front());
      end
      if (st_o_val && st_o_rdy) begin
        if (exp_st.size() == 0) report_fail("st_o_word", "unexpected stream word");
        else check("st_o_word", {st_o_eop, st_o_dat}, exp_st.pop_front());
      end
      if (mm_rval) begin
        if (exp_rd.size() == 0) report_fail("mm_rdat", "unexpected mm_rval");
        else check("mm_rdat", mm_rdat, exp_rd.pop_front());
      end
      if (cs_rval) begin
        if (exp_cs.size() == 0) report_fail("cs_rdat", "unexpected cs_rval");
        else check("cs_rdat", cs_rdat, exp_cs.pop_front());
      end
    end
  end

  // Random backpressure on the sinks the bench plays
  initial begin
    llhp_o.rdy = 1'b1;
    lllp_o.rdy = 1'b1;
    st_o_rdy   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      llhp_o.rdy = hp_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      lllp_o.rdy = lp_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      st_o_rdy   = st_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Issue an MM request and hold it until accepted; expected packet words are the model.
  task automatic mm_op(input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
    int n;
    mm_wreq = wr;
    mm_rreq = !wr;
    mm_addr = a;
    mm_wdat = d;
    n = 0;
    @(negedge clk);
    while (mm_busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (mm_busy) report_fail("mm_accept", "request never accepted");
    else if (wr) begin
      exp_hp.push_back({2'b10, W'(1)});
      exp_hp.push_back({2'b00, a});
      exp_hp.push_back({2'b01, d});
    end else begin
      exp_hp.push_back({2'b10, W'(0)});
      exp_hp.push_back({2'b01, a});
    end
    tick();
    mm_wreq = 1'b0;
    mm_rreq = 1'b0;
  endtask

  // Upstream peer returns a packet; only its eop word carries read data.
  task automatic peer_resp(input int nwords, input logic [W-1:0] last, input bit expect_rval);
    for (int i = 0; i < nwords; i++) begin
      llhp_i.val = 1'b1;
      llhp_i.sop = (i == 0);
      llhp_i.eop = (i == nwords - 1);
      llhp_i.dat = (i == nwords - 1) ? last : W'($urandom);
      if (i == nwords - 1 && expect_rval) exp_rd.push_back(last);
      tick();
    end
    llhp_i.val = 1'b0;
    llhp_i.sop = 1'b0;
    llhp_i.eop = 1'b0;
  endtask

  task automatic wait_hp_drain();
    int n = 0;
    while (exp_hp.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (exp_hp.size() != 0) report_fail("hp_drain", "packet words not delivered");
    tick();
  endtask

  task automatic wait_rd_drain(input int bound);
    int n = 0;
    while (exp_rd.size() != 0 && n < bound) begin
      n++;
      @(negedge clk);
    end
    if (exp_rd.size() != 0) report_fail("rd_drain", "read responses missing");
    tick();
  endtask

  task automatic cs_write(input logic [3:0] a, input logic [CW-1:0] d);
    cs_addr = a;
    cs_wdat = d;
    cs_wreq = 1'b1;
    tick();
    cs_wreq = 1'b0;
  endtask

  task automatic cs_read(input logic [3:0] a, input logic [CW-1:0] exp);
    cs_addr = a;
    cs_rreq = 1'b1;
    exp_cs.push_back(exp);
    tick();
    cs_rreq = 1'b0;
    tick();
  endtask

  // Hold a request while the link is down; return the number of busy cycles before the drop.
  task automatic hold_until_drop(input bit wr, output int n);
    mm_wreq = wr;
    mm_rreq = !wr;
    mm_addr = W'($urandom);
    mm_wdat = W'($urandom);
    n = 0;
    @(negedge clk);
    while (mm_busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    tick();
    mm_wreq = 1'b0;
    mm_rreq = 1'b0;
  endtask

  task automatic st_word(input logic [W-1:0] d, input bit sop, input bit eop);
    int n = 0;
    st_i_dat = d;
    st_i_val = 1'b1;
    st_i_eop = eop;
    exp_lp.push_back({sop, eop, d});
    @(negedge clk);
    check("st_i_rdy_follows", st_i_rdy, lllp_o.rdy);
    while (!lllp_o.rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!lllp_o.rdy) report_fail("st_i_accept", "lllp_o never ready");
    tick();
    st_i_val = 1'b0;
    st_i_eop = 1'b0;
  endtask

  task automatic lp_in_word(input logic [W-1:0] d, input bit eop);
    int n = 0;
    lllp_i.dat = d;
    lllp_i.val = 1'b1;
    lllp_i.eop = eop;
    lllp_i.sop = 1'($urandom);
    exp_st.push_back({eop, d});
    @(negedge clk);
    while (!st_o_rdy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!st_o_rdy) report_fail("lllp_i_accept", "st_o never ready");
    tick();
    lllp_i.val = 1'b0;
    lllp_i.eop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, ones, len;
    bit wr;
    int n_rd;
    cs_addr = '0; cs_wreq = 1'b0; cs_wdat = '0; cs_rreq = 1'b0;
    mm_addr = '0; mm_wreq = 1'b0; mm_wdat = '0; mm_rreq = 1'b0;
    st_i_dat = '0; st_i_val = 1'b0; st_i_eop = 1'b0;
    ll_linkup = 1'b0;
    llhp_i.dat = '0; llhp_i.val = 1'b0; llhp_i.sop = 1'b0; llhp_i.eop = 1'b0;
    lllp_i.dat = '0; lllp_i.val = 1'b0; lllp_i.sop = 1'b0; lllp_i.eop = 1'b0;

    // Values while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ll_reset", ll_reset, 1);
    check("rst_mm_rval", mm_rval, 0);
    check("rst_cs_rval", cs_rval, 0);
    check("rst_llhp_o_val", llhp_o.val, 0);
    check("rst_rdat", {mm_rdat, cs_rdat}, 0);
    check("rst_cs_busy", cs_busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Link down: pulse of 5 cycles every 25, starting at cycle 0
    for (int k = 0; k < 55; k++) begin
      @(negedge clk);
      check("ll_reset_period", ll_reset, ((k % 25) < 5));
    end
    tick();
    ll_linkup = 1'b1;
    @(negedge clk);
    check("ll_reset_linkup", ll_reset, 0);
    tick();

    cs_read(4'd0, 8'h02);
    cs_read(4'd1, 8'h01);
    cs_read(4'd2, 8'h00);
    cs_read(4'd5, 8'h00);

    // Directed write then read with a single-word response
    mm_op(1'b1, 8'h12, 8'h34);
    @(negedge clk);
    check("wr_hdr_latency", {llhp_o.val, llhp_o.sop}, 2'b11);
    wait_hp_drain();
    mm_op(1'b0, 8'h05, 8'h00);
    wait_hp_drain();
    cs_read(4'd1, 8'h05);
    peer_resp(1, 8'hA5, 1'b1);
    @(negedge clk);
    check("rd_rval_latency", mm_rval, 1);
    tick();
    // Response with nothing pending is discarded
    peer_resp(1, 8'h5A, 1'b0);
    repeat (3) tick();

    // Randomized traffic with backpressure and multi-word responses
    hp_bp = 1'b1;
    for (int b = 0; b < 20; b++) begin
      n_rd = 0;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        wr = 1'($urandom);
        mm_op(wr, W'($urandom), W'($urandom));
        if (!wr) n_rd++;
      end
      wait_hp_drain();
      for (int r = 0; r < n_rd; r++) peer_resp(int'($urandom_range(1, 3)), W'($urandom), 1'b1);
      wait_rd_drain(20);
    end
    hp_bp = 1'b0;

    // Eight unanswered reads fill the window; all time out with zero data
    cs_write(4'd3, 8'h00);
    for (int i = 0; i < 8; i++) mm_op(1'b0, W'(i), 8'h00);
    for (int i = 0; i < 9; i++) exp_rd.push_back(8'h00);
    mm_rreq = 1'b1;
    mm_addr = 8'h08;
    @(negedge clk);
    check("busy_at_max_pending", mm_busy, 1);
    tick();
    mm_op(1'b0, 8'h08, 8'h00);
    wait_hp_drain();
    wait_rd_drain(2500);
    cs_read(4'd3, 8'd9);
    cs_read(4'd1, 8'h01);

    // Link down: held write and read are dropped after the busy timeout
    cs_write(4'd3, 8'h00);
    ll_linkup = 1'b0;
    tick();
    hold_until_drop(1'b1, n);
    check("wr_busy_cycles", n, 128);
    repeat (3) tick();
    check("no_hp_after_drop", llhp_o.val, 0);
    cs_read(4'd3, 8'd1);
    exp_rd.push_back(8'h00);
    hold_until_drop(1'b0, n);
    check("rd_busy_cycles", n, 128);
    wait_rd_drain(10);
    cs_read(4'd3, 8'd2);

    // Auto-reset disabled keeps ll_reset low; force bit holds it high
    cs_write(4'd0, 8'h00);
    ones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ll_reset) ones++;
    end
    check("auto_off_no_reset", ones, 0);
    tick();
    ll_linkup = 1'b1;
    cs_write(4'd0, 8'h01);
    @(negedge clk);
    check("force_reset", ll_reset, 1);
    tick();
    cs_read(4'd0, 8'h01);
    cs_read(4'd1, 8'h03);
    cs_write(4'd0, 8'h02);
    @(negedge clk);
    check("force_release", ll_reset, 0);
    tick();

    // Streams in both directions
    lp_bp = 1'b1;
    st_bp = 1'b1;
    st_word(8'hA0, 1'b1, 1'b0);
    st_word(8'hA1, 1'b0, 1'b0);
    st_word(8'hA2, 1'b0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) st_word(W'($urandom), (i == 0), (i == len - 1));
    end
    for (int p = 0; p < 4; p++) begin
      len = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) lp_in_word(W'($urandom), (i == len - 1));
    end
    repeat (5) tick();

    check("hp_queue_empty", exp_hp.size(), 0);
    check("lp_queue_empty", exp_lp.size(), 0);
    check("st_queue_empty", exp_st.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);
    check("cs_queue_empty", exp_cs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
